// File: rtl/axi_slave_bram_256.sv
// AXI4 slave backed by block RAM: one write burst and one read burst in flight, independent channels.
// Define AXI_SLV_RANGE_CHK_EN to answer beats beyond MEM_DEPTH with SLVERR instead of wrapping.
module axi_slave_bram_256 #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_DEPTH  = 4096
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic                    S_AXI_AWID,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [7:0]              S_AXI_AWLEN,
    input  logic                    S_AXI_AWVALID,
    output logic                    S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                    S_AXI_WLAST,
    input  logic                    S_AXI_WVALID,
    output logic                    S_AXI_WREADY,
    output logic                    S_AXI_BID,
    output logic [1:0]              S_AXI_BRESP,
    output logic                    S_AXI_BVALID,
    input  logic                    S_AXI_BREADY,
    input  logic                    S_AXI_ARID,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [7:0]              S_AXI_ARLEN,
    input  logic                    S_AXI_ARVALID,
    output logic                    S_AXI_ARREADY,
    output logic                    S_AXI_RID,
    output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]              S_AXI_RRESP,
    output logic                    S_AXI_RLAST,
    output logic                    S_AXI_RVALID,
    input  logic                    S_AXI_RREADY
);
    localparam int STRB_W  = DATA_WIDTH / 8;
    localparam int BYTE_SH = $clog2(STRB_W);
    localparam int MEM_AW  = $clog2(MEM_DEPTH);
`ifdef AXI_SLV_RANGE_CHK_EN
    localparam int IW = ADDR_WIDTH - BYTE_SH;
`else
    localparam int IW = MEM_AW;
`endif

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA} rstate_t;

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    wstate_t         r_wstate, w_wstate_nxt;
    logic            r_awready, r_wready, r_bvalid, r_bid;
    logic [IW-1:0]   r_widx, w_aw_idx;
    logic [7:0]      r_wbeats;
    logic            w_aw_hs, w_w_hs, w_b_hs, w_wr_oor;

    rstate_t         r_rstate, w_rstate_nxt;
    logic            r_arready, r_rvalid, r_rid;
    logic [IW-1:0]   r_ridx, w_ar_idx, w_fetch_idx;
    logic [7:0]      r_rbeats;
    logic [DATA_WIDTH-1:0] r_rdata_p1;
    logic            w_ar_hs, w_r_hs, w_rlast, w_fetch_en, w_rd_oor;
    logic            w_unused;

    assign w_aw_idx = IW'(S_AXI_AWADDR >> BYTE_SH);
    assign w_ar_idx = IW'(S_AXI_ARADDR >> BYTE_SH);
    assign w_aw_hs  = r_awready & S_AXI_AWVALID;
    assign w_w_hs   = r_wready & S_AXI_WVALID;
    assign w_b_hs   = r_bvalid & S_AXI_BREADY;
    assign w_ar_hs  = r_arready & S_AXI_ARVALID;
    assign w_r_hs   = r_rvalid & S_AXI_RREADY;
    assign w_rlast  = (r_rbeats == 8'd0);

    // Next read address: first word on AR, else the word after the one being handed over
    assign w_fetch_idx = w_ar_hs ? w_ar_idx : r_ridx + IW'(1);
    assign w_fetch_en  = w_ar_hs | (w_r_hs & ~w_rlast);

    // Burst length comes from AWLEN alone; WLAST and sub-word address bits carry no information here
    assign w_unused = &{1'b0, S_AXI_WLAST, S_AXI_AWADDR, S_AXI_ARADDR};

`ifdef AXI_SLV_RANGE_CHK_EN
    logic       r_werr;
    logic [1:0] r_rresp_p1;
    assign w_wr_oor    = (r_widx >= IW'(MEM_DEPTH));
    assign w_rd_oor    = (w_fetch_idx >= IW'(MEM_DEPTH));
    assign S_AXI_BRESP = {r_werr, 1'b0};
    assign S_AXI_RRESP = r_rresp_p1;
`else
    assign w_wr_oor    = 1'b0;
    assign w_rd_oor    = 1'b0;
    assign S_AXI_BRESP = 2'b00;
    assign S_AXI_RRESP = 2'b00;
`endif

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE:  if (w_aw_hs) w_wstate_nxt = W_DATA;
            W_DATA:  if (w_w_hs && r_wbeats == 8'd0) w_wstate_nxt = W_RESP;
            W_RESP:  if (w_b_hs) w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so they stay low throughout reset
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bid     <= 1'b0;
`ifdef AXI_SLV_RANGE_CHK_EN
            r_werr    <= 1'b0;
`endif
        end else begin
            r_wstate  <= w_wstate_nxt;
            r_awready <= (w_wstate_nxt == W_IDLE);
            r_wready  <= (w_wstate_nxt == W_DATA);
            r_bvalid  <= (w_wstate_nxt == W_RESP);
            if (w_aw_hs) r_bid <= S_AXI_AWID;
`ifdef AXI_SLV_RANGE_CHK_EN
            if (w_aw_hs)                  r_werr <= 1'b0;
            else if (w_w_hs && w_wr_oor)  r_werr <= 1'b1;
`endif
        end
    end

    always_ff @(posedge ACLK) begin
        if (w_aw_hs) begin
            r_widx   <= w_aw_idx;
            r_wbeats <= S_AXI_AWLEN;
        end else if (w_w_hs) begin
            r_widx   <= r_widx + IW'(1);
            r_wbeats <= r_wbeats - 8'd1;
        end
    end

    always_ff @(posedge ACLK) begin
        if (w_w_hs && !w_wr_oor) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (S_AXI_WSTRB[b]) r_mem[r_widx[MEM_AW-1:0]][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
            end
        end
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_DATA;
            R_DATA:  if (w_r_hs && w_rlast) w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // RAM output register; the array is sampled before this cycle's write lands, giving read-first
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_rstate   <= R_IDLE;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rid      <= 1'b0;
            r_rdata_p1 <= '0;
`ifdef AXI_SLV_RANGE_CHK_EN
            r_rresp_p1 <= 2'b00;
`endif
        end else begin
            r_rstate  <= w_rstate_nxt;
            r_arready <= (w_rstate_nxt == R_IDLE);
            r_rvalid  <= (w_rstate_nxt == R_DATA);
            if (w_ar_hs) r_rid <= S_AXI_ARID;
            if (w_fetch_en) begin
                r_rdata_p1 <= w_rd_oor ? '0 : r_mem[w_fetch_idx[MEM_AW-1:0]];
`ifdef AXI_SLV_RANGE_CHK_EN
                r_rresp_p1 <= w_rd_oor ? 2'b10 : 2'b00;
`endif
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (w_ar_hs) r_rbeats <= S_AXI_ARLEN;
        else if (w_r_hs) r_rbeats <= r_rbeats - 8'd1;
        if (w_fetch_en) r_ridx <= w_fetch_idx;
    end

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_wready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BID     = r_bid;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RID     = r_rid;
    assign S_AXI_RDATA   = r_rdata_p1;
    assign S_AXI_RLAST   = r_rvalid & w_rlast;
endmodule

// File: tb/tb_axi_slave_bram_256.sv
// Bench for axi_slave_bram_256: directed bursts, a transaction-level memory model checked every cycle,
// and literal expectations for the main scenarios.
module tb_axi_slave_bram_256;
    localparam int DW = 256;
    localparam int SW = 32;
    localparam int DEPTH = 4096;

    logic ACLK = 1'b0;
    logic ARESETN = 1'b1;
    logic AWID = 0, ARID = 0, AWVALID = 0, WLAST = 0, WVALID = 0, BREADY = 0, ARVALID = 0, RREADY = 0;
    logic [31:0] AWADDR = 0, ARADDR = 0;
    logic [7:0] AWLEN = 0, ARLEN = 0;
    logic [DW-1:0] WDATA = 0;
    logic [SW-1:0] WSTRB = 0;
    logic AWREADY, WREADY, BID, BVALID, ARREADY, RID, RLAST, RVALID;
    logic [1:0] BRESP, RRESP;
    logic [DW-1:0] RDATA;

    always #5 ACLK = ~ACLK;

    axi_slave_bram_256 #(.DATA_WIDTH(DW), .ADDR_WIDTH(32), .MEM_DEPTH(DEPTH)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWID(AWID), .S_AXI_AWADDR(AWADDR), .S_AXI_AWLEN(AWLEN),
        .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
        .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WLAST(WLAST),
        .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
        .S_AXI_BID(BID), .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
        .S_AXI_ARID(ARID), .S_AXI_ARADDR(ARADDR), .S_AXI_ARLEN(ARLEN),
        .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
        .S_AXI_RID(RID), .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RLAST(RLAST),
        .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    task automatic timeout_fail(input string name);
        n_total++;
        $display("FAIL %s: no handshake within the cycle budget", name);
    endtask

    // ---------------- behavioural model: word store with per-byte known flags ----------------
    logic [DW-1:0] m_data [int];
    logic [SW-1:0] m_known [int];
    int mw_ph = 0, mr_ph = 0;          // 0: just out of reset, 1: idle, 2: data, 3: response
    logic [26:0] mw_idx, mr_idx;
    int mw_left, mr_left;
    logic mw_id, mr_id, mw_err;
    logic [DW-1:0] mr_data, mr_mask;
    logic [1:0] mr_resp;

    function automatic bit is_oor(input logic [26:0] idx);
`ifdef AXI_SLV_RANGE_CHK_EN
        return idx >= 27'(DEPTH);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int wkey(input logic [26:0] idx);
        return int'(idx) % DEPTH;
    endfunction

    task automatic fetch(input logic [26:0] idx);
        int k;
        logic [SW-1:0] kn;
        if (is_oor(idx)) begin
            mr_data = '0; mr_mask = '1; mr_resp = 2'b10;
        end else begin
            k = wkey(idx);
            mr_data = m_data.exists(k) ? m_data[k] : '0;
            kn = m_known.exists(k) ? m_known[k] : '0;
            for (int b = 0; b < SW; b++) mr_mask[b*8 +: 8] = {8{kn[b]}};
            mr_resp = 2'b00;
        end
    endtask

    task automatic apply_w(input logic [26:0] idx, input logic [DW-1:0] d, input logic [SW-1:0] s);
        int k;
        if (!is_oor(idx)) begin
            k = wkey(idx);
            if (!m_data.exists(k)) begin m_data[k] = '0; m_known[k] = '0; end
            for (int b = 0; b < SW; b++) if (s[b]) begin
                m_data[k][b*8 +: 8] = d[b*8 +: 8];
                m_known[k][b] = 1'b1;
            end
        end
    endtask

    // Compare on the falling edge, then advance the model by the handshakes the next rising edge will see
    always @(negedge ACLK) begin
        if (!ARESETN) begin
            chk("reset_ctl", {AWREADY, WREADY, BVALID, BRESP, BID, ARREADY, RVALID, RLAST, RRESP, RID}, '0);
            chk("reset_rdata", RDATA, '0);
            mw_ph = 0; mr_ph = 0;
        end else begin
            chk("ready_valid", {AWREADY, WREADY, BVALID, ARREADY, RVALID},
                {mw_ph == 1, mw_ph == 2, mw_ph == 3, mr_ph == 1, mr_ph == 2});
            if (mw_ph == 3) chk("bid_bresp", {BID, BRESP}, {mw_id, mw_err, 1'b0});
            if (mr_ph == 2) begin
                chk("rid_rresp_rlast", {RID, RRESP, RLAST}, {mr_id, mr_resp, mr_left == 0});
                chk("rdata", RDATA & mr_mask, mr_data & mr_mask);
            end
            // read side first: a read issued this cycle sees memory before this cycle's write
            if (mr_ph == 0) mr_ph = 1;
            else if (mr_ph == 1 && ARVALID) begin
                mr_idx = 27'(ARADDR >> 5); mr_left = int'(ARLEN); mr_id = ARID;
                fetch(mr_idx); mr_ph = 2;
            end else if (mr_ph == 2 && RREADY) begin
                if (mr_left == 0) mr_ph = 1;
                else begin mr_left--; mr_idx = mr_idx + 27'd1; fetch(mr_idx); end
            end
            if (mw_ph == 0) mw_ph = 1;
            else if (mw_ph == 1 && AWVALID) begin
                mw_idx = 27'(AWADDR >> 5); mw_left = int'(AWLEN); mw_id = AWID; mw_err = 1'b0; mw_ph = 2;
            end else if (mw_ph == 2 && WVALID) begin
                if (is_oor(mw_idx)) mw_err = 1'b1;
                apply_w(mw_idx, WDATA, WSTRB);
                mw_idx = mw_idx + 27'd1;
                if (mw_left == 0) mw_ph = 3; else mw_left--;
            end else if (mw_ph == 3 && BREADY) mw_ph = 1;
        end
    end

    // ---------------- stimulus ----------------
    logic [DW-1:0] rd_cap [256];
    int rd_n;
    logic rd_last;

    function automatic logic rdy(input int s);
        case (s)
            0: return AWREADY;
            1: return WREADY;
            2: return BVALID;
            default: return ARREADY;
        endcase
    endfunction

    task automatic wait_hs(input int s, input string nm, output logic [1:0] resp);
        int n = 0;
        bit hs = 0;
        resp = 2'b00;
        do begin
            @(negedge ACLK); hs = rdy(s); if (hs) resp = BRESP;
            @(posedge ACLK); #1; n++;
        end while (!hs && n < 2000);
        if (!hs) timeout_fail(nm);
    endtask

    task automatic wr_burst(input logic [31:0] addr, input logic [7:0] len, input logic id,
                            input logic [DW-1:0] base, input logic [SW-1:0] strb, output logic [1:0] bresp);
        logic [1:0] dummy;
        AWADDR = addr; AWLEN = len; AWID = id; AWVALID = 1'b1;
        wait_hs(0, "aw_timeout", dummy);
        AWVALID = 1'b0;
        for (int k = 0; k <= int'(len); k++) begin
            WDATA = base + DW'(k); WSTRB = strb; WLAST = (k == int'(len)); WVALID = 1'b1;
            wait_hs(1, "w_timeout", dummy);
        end
        WVALID = 1'b0; WLAST = 1'b0;
        BREADY = 1'b1;
        wait_hs(2, "b_timeout", bresp);
        BREADY = 1'b0;
    endtask

    task automatic rd_burst(input logic [31:0] addr, input logic [7:0] len, input logic id, input bit toggle);
        int c = 0;
        bit done = 0;
        logic [1:0] dummy;
        rd_n = 0; rd_last = 1'b0;
        ARADDR = addr; ARLEN = len; ARID = id; ARVALID = 1'b1;
        wait_hs(3, "ar_timeout", dummy);
        ARVALID = 1'b0;
        while (!done && c < 2000) begin
            RREADY = toggle ? (c % 3 == 0) : 1'b1;
            @(negedge ACLK);
            if (RVALID && RREADY) begin
                rd_cap[rd_n] = RDATA; rd_n++;
                if (RLAST) begin done = 1; rd_last = 1'b1; end
            end
            @(posedge ACLK); #1; c++;
        end
        RREADY = 1'b0;
        if (!done) timeout_fail("r_timeout");
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        logic [1:0] br;
        int cnt;
        #2 ARESETN = 1'b0;
        repeat (3) @(posedge ACLK);
        #1 ARESETN = 1'b1;
        repeat (2) @(posedge ACLK);
        #1;

        // full 256-beat write of beat numbers, then read back
        wr_burst(32'h0, 8'd255, 1'b1, '0, '1, br);
        chk("t1_bresp", br, 2'b00);
        rd_burst(32'h0, 8'd255, 1'b1, 1'b0);
        chk("t1_beats", rd_n, 256);
        chk("t1_beat0", rd_cap[0], 0);
        chk("t1_beat200", rd_cap[200], 200);
        chk("t1_beat255", rd_cap[255], 255);

        // partial strobe over a zeroed word
        wr_burst(32'h40, 8'd0, 1'b0, '0, '1, br);
        wr_burst(32'h40, 8'd0, 1'b0, DW'(32'hAABBCCDD), 32'h0000_000F, br);
        rd_burst(32'h40, 8'd0, 1'b0, 1'b0);
        chk("t2_strobe", rd_cap[0], DW'(32'hAABBCCDD));

        // stalled 4-beat read
        rd_burst(32'h100, 8'd3, 1'b1, 1'b1);
        chk("t3_beats", rd_n, 4);
        chk("t3_beat3", rd_cap[3], 11);
        chk("t3_rlast", rd_last, 1'b1);

        // simultaneous write and read of the same four words
        wr_burst(32'h280, 8'd3, 1'b0, DW'(32'h1000), '1, br);
        fork
            wr_burst(32'h280, 8'd3, 1'b1, DW'(32'h2000), '1, br);
            rd_burst(32'h280, 8'd3, 1'b0, 1'b0);
        join
        chk("t4_old0", rd_cap[0], DW'(32'h1000));
        chk("t4_old3", rd_cap[3], DW'(32'h1003));
        rd_burst(32'h280, 8'd3, 1'b1, 1'b0);
        chk("t4_new2", rd_cap[2], DW'(32'h2002));

        // reset during beat 10 of a long read
        ARADDR = 32'h0; ARLEN = 8'd255; ARID = 1'b1; ARVALID = 1'b1;
        wait_hs(3, "t5_ar_timeout", br);
        ARVALID = 1'b0; RREADY = 1'b1; cnt = 0;
        for (int c = 0; c < 40 && cnt < 10; c++) begin
            @(negedge ACLK); if (RVALID) cnt++;
            @(posedge ACLK); #1;
        end
        ARESETN = 1'b0;
        #1 chk("t5_rvalid_async", RVALID, 1'b0);
        RREADY = 1'b0;
        repeat (2) @(posedge ACLK);
        #1 ARESETN = 1'b1;
        rd_burst(32'h60, 8'd0, 1'b0, 1'b0);
        chk("t5_beats", rd_n, 1);
        chk("t5_rlast", rd_last, 1'b1);
        chk("t5_data", rd_cap[0], 3);

        // burst crossing the top of the memory
        wr_burst(32'h0001_FFE0, 8'd1, 1'b1, DW'(32'h77), '1, br);
        rd_burst(32'h0001_FFE0, 8'd1, 1'b0, 1'b0);
        chk("t6_beat0", rd_cap[0], DW'(32'h77));
        rd_burst(32'h0, 8'd0, 1'b1, 1'b0);
`ifdef AXI_SLV_RANGE_CHK_EN
        chk("t6_bresp", br, 2'b10);
        chk("t6_word0_untouched", rd_cap[0], 0);
`else
        chk("t6_bresp", br, 2'b00);
        chk("t6_word0_wrapped", rd_cap[0], DW'(32'h78));
`endif

        repeat (3) @(posedge ACLK);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
